byte_mem: RTL and testbench

BYTE_MEM -- requirements
Module: byte_mem

---
 rtl/mem_pkg.sv | 11 +
 rtl/mem_array.sv | 39 +++
 rtl/byte_mem.sv | 112 +++++++++++
 tb/tb_byte_mem.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the byte-addressable memory block.
package mem_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

endpackage

// File: rtl/mem_array.sv
// Word storage with byte-enable writes and a registered read port; no reset on contents.
module mem_array
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 2 ** ADDR_W
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [DATA_W/BYTE_W-1:0] i_be,
    input  logic [ADDR_W-1:0]        i_addr,
    input  logic [DATA_W-1:0]        i_wdata,
    input  logic                     i_re,
    output logic [DATA_W-1:0]        o_rdata
);

    localparam int unsigned NB = DATA_W / BYTE_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Read register only loads on a read, so the last read word is held.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int i = 0; i < NB; i++) begin
                if (i_be[i]) begin
                    r_mem[i_addr][i*BYTE_W +: BYTE_W] <= i_wdata[i*BYTE_W +: BYTE_W];
                end
            end
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/byte_mem.sv
// Byte-enable memory with request handshake, range check and a word-at-a-time clear FSM.
// Define BYTE_MEM_INIT_CLEAR_EN to reset into CLEAR so storage reads as zero after DEPTH cycles.
module byte_mem
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 2 ** ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req,
    input  logic                     we,
    input  logic [DATA_W/BYTE_W-1:0] be,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     clr,
    output logic                     ready,
    output logic                     rvalid,
    output logic [DATA_W-1:0]        rdata,
    output logic                     err
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST    = (ADDR_W + 1)'(DEPTH - 1);

`ifdef BYTE_MEM_INIT_CLEAR_EN
    localparam state_e RST_STATE = CLEAR;
`else
    localparam state_e RST_STATE = IDLE;
`endif

    state_e          r_state;
    logic [ADDR_W:0] r_clr_cnt;
    logic            r_rvalid;
    logic            r_err;
    logic            r_rd_zero;

    logic                     w_acc;
    logic                     w_in_range;
    logic                     w_clearing;
    logic                     w_mem_we;
    logic                     w_mem_re;
    logic [DATA_W/BYTE_W-1:0] w_mem_be;
    logic [ADDR_W-1:0]        w_mem_addr;
    logic [DATA_W-1:0]        w_mem_wdata;
    logic [DATA_W-1:0]        w_mem_q;

    assign ready      = (r_state == IDLE);
    assign w_acc      = req & ready;
    assign w_in_range = ({1'b0, addr} < DEPTH_L);
    assign w_clearing = (r_state == CLEAR);

    assign w_mem_we    = w_clearing | (w_acc & we & w_in_range);
    assign w_mem_re    = w_acc & ~we & w_in_range;
    assign w_mem_be    = w_clearing ? '1 : be;
    assign w_mem_addr  = w_clearing ? r_clr_cnt[ADDR_W-1:0] : addr;
    assign w_mem_wdata = w_clearing ? '0 : wdata;

    mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem_array (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_be    (w_mem_be),
        .i_addr  (w_mem_addr),
        .i_wdata (w_mem_wdata),
        .i_re    (w_mem_re),
        .o_rdata (w_mem_q)
    );

    // r_rd_zero masks the un-reset array register after reset and after out-of-range reads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= RST_STATE;
            r_clr_cnt <= '0;
            r_rvalid  <= 1'b0;
            r_err     <= 1'b0;
            r_rd_zero <= 1'b1;
        end else begin
            r_rvalid <= w_acc & ~we;
            r_err    <= w_acc & ~w_in_range;
            if (w_acc && !we) begin
                r_rd_zero <= ~w_in_range;
            end
            case (r_state)
                IDLE: begin
                    if (clr) begin
                        r_state   <= CLEAR;
                        r_clr_cnt <= '0;
                    end
                end
                CLEAR: begin
                    if (r_clr_cnt == LAST) begin
                        r_state   <= IDLE;
                        r_clr_cnt <= '0;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rvalid = r_rvalid;
    assign err    = r_err;
    assign rdata  = r_rd_zero ? '0 : w_mem_q;

endmodule

// File: tb/tb_byte_mem.sv
// Directed self-checking bench for byte_mem (DEPTH = 1000, ADDR_W = 10).
module tb_byte_mem;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic        clr;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;
    int n_clr;

    byte_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .we     (we),
        .be     (be),
        .addr   (addr),
        .wdata  (wdata),
        .clr    (clr),
        .ready  (ready),
        .rvalid (rvalid),
        .rdata  (rdata),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic write_one(input logic [9:0] a, input logic [31:0] d, input logic [3:0] b,
                             input string tag);
        addr = a; wdata = d; be = b; we = 1'b1; req = 1'b1;
        step();
        req = 1'b0; we = 1'b0;
        check({tag, "_rvalid"}, {31'd0, rvalid}, 32'd0);
        check({tag, "_err"}, {31'd0, err}, 32'd0);
    endtask

    task automatic read_one(input logic [9:0] a, input logic [31:0] exp, input string tag);
        addr = a; we = 1'b0; req = 1'b1;
        step();
        req = 1'b0;
        check({tag, "_rvalid"}, {31'd0, rvalid}, 32'd1);
        check({tag, "_rdata"}, rdata, exp);
        check({tag, "_err"}, {31'd0, err}, 32'd0);
        step();
        check({tag, "_rvalid_drop"}, {31'd0, rvalid}, 32'd0);
        check({tag, "_rdata_hold"}, rdata, exp);
    endtask

    // Counts samples with ready low, starting at the current sample; pulses clr at sample pulse_at.
    task automatic count_clear(input int pulse_at, output int n);
        n = 0;
        while (ready !== 1'b1 && n < 3000) begin
            n++;
            clr = (n == pulse_at);
            step();
            clr = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b0; req = 1'b0; we = 1'b0; be = '0; addr = '0; wdata = '0; clr = 1'b0;
        #12;
        check("rst_rvalid", {31'd0, rvalid}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
`ifdef BYTE_MEM_INIT_CLEAR_EN
        check("rst_ready", {31'd0, ready}, 32'd0);
`else
        check("rst_ready", {31'd0, ready}, 32'd1);
`endif
        step();
        rst = 1'b1;
`ifdef BYTE_MEM_INIT_CLEAR_EN
        count_clear(0, n_clr);
        check("init_clear_len", n_clr, 32'd1000);
        read_one(10'd5, 32'd0, "init_rd5");
`else
        check("init_ready", {31'd0, ready}, 32'd1);
`endif

        // Byte-enable merge: bytes 0 and 2 take the new data.
        write_one(10'd3, 32'h1122_3344, 4'b1111, "wr3_full");
        write_one(10'd3, 32'hAABB_CCDD, 4'b0101, "wr3_part");
        read_one(10'd3, 32'h11BB_33DD, "rd3_merge");

        // Back-to-back reads.
        write_one(10'd0, 32'h0000_000A, 4'b1111, "wr0");
        write_one(10'd1, 32'h0000_000B, 4'b1111, "wr1");
        write_one(10'd2, 32'h0000_000C, 4'b1111, "wr2");
        addr = 10'd0; we = 1'b0; req = 1'b1;
        step();
        check("b2b0_rvalid", {31'd0, rvalid}, 32'd1);
        check("b2b0_rdata", rdata, 32'h0000_000A);
        addr = 10'd1;
        step();
        check("b2b1_rvalid", {31'd0, rvalid}, 32'd1);
        check("b2b1_rdata", rdata, 32'h0000_000B);
        addr = 10'd2;
        step();
        req = 1'b0;
        check("b2b2_rvalid", {31'd0, rvalid}, 32'd1);
        check("b2b2_rdata", rdata, 32'h0000_000C);
        step();
        check("b2b_end_rvalid", {31'd0, rvalid}, 32'd0);

        // Range boundary: 999 is the last word, 1000 is out of range.
        write_one(10'd999, 32'h1234_5678, 4'b1111, "wr999");
        addr = 10'd1000; wdata = 32'hFFFF_FFFF; be = 4'b1111; we = 1'b1; req = 1'b1;
        step();
        req = 1'b0; we = 1'b0;
        check("oor_wr_err", {31'd0, err}, 32'd1);
        check("oor_wr_rvalid", {31'd0, rvalid}, 32'd0);
        step();
        check("oor_wr_err_drop", {31'd0, err}, 32'd0);
        read_one(10'd999, 32'h1234_5678, "rd999");
        addr = 10'd1000; we = 1'b0; req = 1'b1;
        step();
        req = 1'b0;
        check("oor_rd_rvalid", {31'd0, rvalid}, 32'd1);
        check("oor_rd_err", {31'd0, err}, 32'd1);
        check("oor_rd_rdata", rdata, 32'd0);
        step();
        check("oor_rd_err_drop", {31'd0, err}, 32'd0);
        check("oor_rd_rvalid_drop", {31'd0, rvalid}, 32'd0);

        // clr together with a write; second clr mid-clear must not extend it.
        addr = 10'd7; wdata = 32'h0000_0055; be = 4'b1111; we = 1'b1; req = 1'b1; clr = 1'b1;
        step();
        req = 1'b0; we = 1'b0; clr = 1'b0;
        check("clr_wr_err", {31'd0, err}, 32'd0);
        check("clr_ready_low", {31'd0, ready}, 32'd0);
        count_clear(500, n_clr);
        check("clr_len", n_clr, 32'd1000);
        read_one(10'd7, 32'd0, "clr_rd7");
        read_one(10'd3, 32'd0, "clr_rd3");
        read_one(10'd999, 32'd0, "clr_rd999");

        // Reset during an outstanding read response.
        write_one(10'd4, 32'hDEAD_BEEF, 4'b1111, "wr4");
        addr = 10'd4; we = 1'b0; req = 1'b1;
        step();
        req = 1'b0;
        check("pre_rst_rvalid", {31'd0, rvalid}, 32'd1);
        check("pre_rst_rdata", rdata, 32'hDEAD_BEEF);
        rst = 1'b0;
        #1;
        check("rd_rst_rvalid", {31'd0, rvalid}, 32'd0);
        check("rd_rst_rdata", rdata, 32'd0);
        step();
        rst = 1'b1;
`ifndef BYTE_MEM_INIT_CLEAR_EN
        clr = 1'b1;
        step();
        clr = 1'b0;
`endif
        // Reset partway through a clear; the next clear must run the full length.
        for (int i = 0; i < 300; i++) step();
        check("mid_clr_ready", {31'd0, ready}, 32'd0);
        rst = 1'b0;
        #1;
        check("clr_rst_rvalid", {31'd0, rvalid}, 32'd0);
        check("clr_rst_rdata", rdata, 32'd0);
        step();
        rst = 1'b1;
`ifndef BYTE_MEM_INIT_CLEAR_EN
        check("clr_rst_ready", {31'd0, ready}, 32'd1);
        clr = 1'b1;
        step();
        clr = 1'b0;
`endif
        count_clear(0, n_clr);
        check("restart_clr_len", n_clr, 32'd1000);
        read_one(10'd4, 32'd0, "restart_rd4");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
